imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Registered immediate extender with valid/ready flow control for the decode stage.
//  Takes an IN_W-bit instruction immediate plus a 2-bit mode.
//  Produces an OUT_W-bit operand: zero-extended, sign-extended, upper-loaded (LUI) or branch offset.
//  Sits between instruction decode and the ALU operand mux.
//  An internal skid buffer lets it absorb execute-stage stalls without losing data.
// PARAMETERS
//  IN_W   16  immediate input width, legal >= 2
//  OUT_W  32  extended output width, legal >= IN_W+2
//  CNT_W  16  width of transfer counter (used only with IMM_EXT_CNT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        upstream presents imm/mode
//  in_ready   out  1        block can accept this cycle
//  in_imm     in   IN_W     raw immediate field
//  in_mode    in   2        00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts this cycle
//  out_data   out  OUT_W    extended operand
//  xfer_cnt   out  CNT_W    accepted-input count (only with IMM_EXT_CNT_EN)
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, skid empty, in_ready=1, xfer_cnt=0.
//  Handshakes:
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - in_ready depends on internal state only; it is a registered/state-derived signal and
//     has no combinational path from in_valid.
//  Extension rules (E = OUT_W-IN_W):
//   - 00: {E{1'b0}}, imm
//   - 01: {E{imm[IN_W-1]}}, imm
//   - 10: imm, {E{1'b0}}
//   - 11: {(E-2){imm[IN_W-1]}}, imm, 2'b00 (sign-extended word offset << 2)
//  Storage: one output register (OR) and one skid register (SK).
//  States: EMPTY (OR, SK invalid), ONE (OR valid), FULL (OR and SK valid).
//  in_ready = (state != FULL).
//  Transitions:
//   - EMPTY + in xfer -> ONE. The result is in OR next cycle: latency 1 clk.
//   - ONE, in xfer & out xfer -> ONE (OR reloads with new data).
//   - ONE, in xfer & !out_ready -> FULL (new data into SK).
//   - ONE, out xfer only -> EMPTY.
//   - FULL, out xfer -> ONE (SK moves to OR); no input accepted in FULL.
//  Data rules:
//   - Strict FIFO ordering.
//   - out_data is held stable while out_valid & !out_ready.
//   - out_data keeps its last value when out_valid=0.
//  Reset asserted mid-operation discards both entries immediately; no partial output.
// CONFIGURATION
//  IMM_EXT_CNT_EN defined:
//   - xfer_cnt port exists and increments on every input transfer.
//   - xfer_cnt wraps from 2^CNT_W-1 to 0.
//  IMM_EXT_CNT_EN undefined:
//   - xfer_cnt port and counter logic are absent.
//   - Datapath and handshake behaviour are identical to the defined build.
// TESTING (IN_W=16, OUT_W=32, out_ready=1 unless stated)
//  1. Each mode with imm=16'h8000 -> out_data 32'h00008000 / FFFF8000 / 80000000 / FFFE0000, one cycle after accept.
//  2. Mode 11 imm=16'h0001 -> 32'h00000004; mode 01 imm=16'h7FFF -> 32'h00007FFF.
//  3. Hold out_ready=0 and push A=16'h0001, B=16'h0002 (mode 01).
//     -> in_ready=0 after B is accepted; out_data stays 32'h1 while stalled.
//     -> Releasing out_ready gives 32'h1, then 32'h2, then out_valid=0.
//  4. Back-to-back streaming with out_ready=1 for 8 cycles -> 8 results, no bubbles, in_ready stays 1.
//  5. Drop rst_n while FULL -> out_valid=0, in_ready=1 with no clock edge; no stale data after release.
//  6. IMM_EXT_CNT_EN, CNT_W=4: make 17 input transfers -> xfer_cnt=1 (wrapped); stalled cycles do not count.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-entry output/skid buffer and valid/ready flow control.
// Optional accepted-input counter on xfer_cnt is enabled by defining IMM_EXT_CNT_EN.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   or_d;
    logic [OUT_W-1:0]   sk_q, sk_d;
    logic [OUT_W-1:0]   ext_c;
    logic [OUT_W-1:0]   sext_c;
    logic               in_xfer_c;

    if (IN_W < 2) begin : g_bad_in_w
        $error("IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("OUT_W must be >= IN_W+2");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    assign in_xfer_c = in_valid & in_ready;

    // Extension of the incoming immediate; branch offset is the sign-extended word index << 2.
    always_comb begin
        sext_c = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        ext_c  = '0;
        unique case (in_mode)
            2'b00:   ext_c = {{EXT_W{1'b0}}, in_imm};
            2'b01:   ext_c = sext_c;
            2'b10:   ext_c = {in_imm, {EXT_W{1'b0}}};
            default: ext_c = sext_c << 2;
        endcase
    end

    // Next-state and buffer steering; output register reloads only on accepted data.
    always_comb begin
        state_d = state_q;
        or_d    = out_data;
        sk_d    = sk_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    or_d    = ext_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_valid && out_ready) begin
                    or_d = ext_c;
                end else if (in_valid) begin
                    sk_d    = ext_c;
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    or_d    = sk_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_data  <= '0;
            sk_q      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_data  <= or_d;
            sk_q      <= sk_d;
            in_ready  <= (state_d != ST_FULL);
            out_valid <= (state_d != ST_EMPTY);
        end
    end

`ifdef IMM_EXT_CNT_EN
    // Counts accepted inputs, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (in_xfer_c) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_c;
    assign unused_c = in_xfer_c;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed and random stimulus checked against a two-deep queue model.
module tb_imm_extend_pipe;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0]  xfer_cnt;
`endif

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned    total = 0;
    int unsigned    bad   = 0;
    logic [31:0]    q[$];
    int unsigned    n_out;
    int unsigned    n_in;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        int s;
        s = int'($signed(imm));
        case (m)
            2'd0:    return 32'(imm);
            2'd1:    return 32'(s);
            2'd2:    return 32'(imm) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check departing data before the edge, update the model, check flags after it.
    task automatic cyc();
        logic        ix, ox, held;
        logic [31:0] held_val, in_exp;
        ix       = in_valid & in_ready;
        ox       = out_valid & out_ready;
        in_exp   = ref_ext(in_imm, in_mode);
        held     = out_valid & ~out_ready;
        held_val = out_data;
        if (ox) begin
            n_out++;
            if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else               chk("order", 64'(out_data), 64'(q.pop_front()));
        end
        @(posedge clk);
        #1;
        if (ix) begin
            q.push_back(in_exp);
            n_in++;
        end
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (held) chk("hold", 64'(out_data), 64'(held_val));
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] m);
        in_valid = v;
        in_imm   = imm;
        in_mode  = m;
    endtask

    initial begin
        logic [31:0] exp1 [4];
        exp1[0] = 32'h0000_8000;
        exp1[1] = 32'hFFFF_8000;
        exp1[2] = 32'h8000_0000;
        exp1[3] = 32'hFFFE_0000;
        n_out = 0;
        n_in  = 0;

        rst_n = 1'b0;
        drive(1'b0, 16'h0, 2'd0);
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Every mode on 0x8000, result visible one cycle after accept.
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 16'h8000, 2'(m));
            cyc();
            chk("mode_8000_valid", 64'(out_valid), 64'd1);
            chk("mode_8000_data", 64'(out_data), 64'(exp1[m]));
            drive(1'b0, 16'h0, 2'd0);
            cyc();
        end
        drive(1'b1, 16'h0001, 2'd3);
        cyc();
        chk("branch_1", 64'(out_data), 64'h0000_0004);
        drive(1'b1, 16'h7FFF, 2'd1);
        cyc();
        chk("sext_7fff", 64'(out_data), 64'h0000_7FFF);
        drive(1'b0, 16'h0, 2'd0);
        cyc();

        // Stall with two entries queued, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'd1);
        cyc();
        drive(1'b1, 16'h0002, 2'd1);
        cyc();
        drive(1'b0, 16'h0, 2'd0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc();
        cyc();
        chk("stall_data", 64'(out_data), 64'h1);
        out_ready = 1'b1;
        chk("drain_first", 64'(out_data), 64'h1);
        cyc();
        chk("drain_second", 64'(out_data), 64'h2);
        cyc();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Back-to-back streaming without bubbles.
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i * 16'h1111), 2'(i));
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            cyc();
        end
        drive(1'b0, 16'h0, 2'd0);
        cyc();
        chk("stream_count", 64'(n_out), 64'd8);

        // Reset while full clears both entries without a clock edge.
        out_ready = 1'b0;
        drive(1'b1, 16'hABCD, 2'd1);
        cyc();
        drive(1'b1, 16'h1234, 2'd2);
        cyc();
        drive(1'b0, 16'h0, 2'd0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        chk("post_rst_no_stale", 64'(out_valid), 64'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cyc();
        end
        drive(1'b0, 16'h0, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("final_empty", 64'(q.size()), 64'd0);

`ifdef IMM_EXT_CNT_EN
        // Counter wraps after 17 accepted inputs; stalled attempts are not counted.
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("cnt_rst", 64'(xfer_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_in = 0;
        for (int i = 0; i < 200 && n_in < 17; i++) begin
            drive(1'b1, 16'($urandom), 2'($urandom_range(0, 3)));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            chk("cnt_track", 64'(xfer_cnt), 64'(CNT_W'(n_in)));
        end
        drive(1'b0, 16'h0, 2'd0);
        cyc();
        chk("cnt_wrap", 64'(xfer_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
